// File: rtl/host_responder_pkg.sv
// Shared definitions for the host-side matrix load / result writeback responder.
package host_responder_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        CAPTURE = 2'd2,
        SEND    = 2'd3
    } state_t;

    localparam int N_ELEMS = 8;
    localparam int N_RES   = 4;

    // Result words cross the pins least-significant byte first; the MMU packs to match.
    localparam logic RES_LSB_FIRST = 1'b1;

endpackage

// File: rtl/host_responder_res_serializer.sv
// Result buffer plus byte serialiser: stores RW-bit results, emits them one DW byte per handshake.
// Latency: a stored word is available the cycle after capture; out_data is combinational from the buffer.
// Backpressure: out_data holds while out_ready is low; byte index advances only on out_valid && out_ready.
module res_serializer #(
    parameter int DW    = 8,
    parameter int RW    = 16,
    parameter int N_RES = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [1:0]    wr_idx,
    input  logic [RW-1:0] wr_data,
    input  logic          send,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          send_last,
    output logic          wb_done
);
    import host_responder_pkg::*;

    logic [RW-1:0] res_buf [N_RES];
    logic [2:0]    byte_idx;
    logic [RW-1:0] cur_word;
    logic          hi_sel;

    assign cur_word  = res_buf[byte_idx[2:1]];
    assign hi_sel    = byte_idx[0] ^ ~RES_LSB_FIRST;
    assign out_valid = send;
    assign out_data  = send ? (hi_sel ? cur_word[RW-1:DW] : cur_word[DW-1:0]) : '0;
    assign send_last = send && out_ready && (byte_idx == 3'(2*N_RES-1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_RES; i++) res_buf[i] <= '0;
            byte_idx <= '0;
            wb_done  <= 1'b0;
        end else begin
            if (wr_en) res_buf[wr_idx] <= wr_data;
            if (!send || send_last)
                byte_idx <= '0;
            else if (out_ready)
                byte_idx <= byte_idx + 3'd1;
            wb_done <= send_last;
        end
    end

endmodule

// File: rtl/host_responder.sv
// Host responder: loads 8 pin bytes into weight memory, then returns 4 MMU results as 8 pin bytes.
// Latency: accepted byte reaches weight memory 1 cycle later; result bytes stream 1 per cycle in SEND.
// Backpressure: in_ready is registered and throttles the host; out_ready stalls the result stream.
module host_responder #(
    parameter int DW      = 8,
    parameter int RW      = 16,
    parameter int N_ELEMS = host_responder_pkg::N_ELEMS,
    parameter int N_RES   = host_responder_pkg::N_RES
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          host_req_mat,
    input  logic          host_mat_wb,
    input  logic [DW-1:0] in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [DW-1:0] elem_data,
    output logic [2:0]    elem_addr,
    output logic          elem_we,
    output logic          load_done,
    input  logic [RW-1:0] res_data,
    input  logic          res_valid,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          wb_done,
    output logic          busy
);
    import host_responder_pkg::*;

    state_t     state_q, state_d;
    logic [3:0] elem_cnt;
    logic [3:0] cnt_nxt;
    logic [2:0] res_cnt;
    logic       accept;
    logic       load_full;
    logic       res_last;
    logic       send_last;

    assign accept    = in_valid && in_ready;
    assign cnt_nxt   = elem_cnt + {3'd0, accept};
    assign load_full = (elem_cnt == 4'(N_ELEMS));
    assign res_last  = res_valid && (res_cnt == 3'(N_RES-1));
    assign busy      = (state_q != IDLE);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (host_req_mat)     state_d = LOAD;
                else if (host_mat_wb) state_d = CAPTURE;
            end
            // A completed load wins over a request that drops in the same cycle.
            LOAD:    if (load_full || !host_req_mat) state_d = IDLE;
            CAPTURE: if (res_last) state_d = SEND;
            SEND:    if (send_last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            elem_cnt  <= '0;
            res_cnt   <= '0;
            in_ready  <= 1'b0;
            elem_we   <= 1'b0;
            elem_data <= '0;
            elem_addr <= '0;
            load_done <= 1'b0;
        end else begin
            state_q <= state_d;

            // Registered ready: low in the first LOAD cycle, drops once the 8th byte is taken.
            in_ready <= (state_q == LOAD) && (state_d == LOAD) && (cnt_nxt < 4'(N_ELEMS));

            elem_we <= accept;
            if (accept) begin
                elem_data <= in_data;
                elem_addr <= elem_cnt[2:0];
            end
            elem_cnt  <= (state_d == LOAD) ? cnt_nxt : 4'd0;
            load_done <= (state_q == LOAD) && load_full;

            if (state_q != CAPTURE || res_last)
                res_cnt <= '0;
            else if (res_valid)
                res_cnt <= res_cnt + 3'd1;
        end
    end

    res_serializer #(
        .DW    (DW),
        .RW    (RW),
        .N_RES (N_RES)
    ) u_ser (
        .clk       (clk),
        .rst       (rst),
        .wr_en     ((state_q == CAPTURE) && res_valid),
        .wr_idx    (res_cnt[1:0]),
        .wr_data   (res_data),
        .send      (state_q == SEND),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .send_last (send_last),
        .wb_done   (wb_done)
    );

endmodule

// File: tb/tb_host_responder.sv
// Directed + randomized bench for host_responder with a queue-based reference model.
module tb_host_responder;
    localparam int DW = 8;
    localparam int RW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          host_req_mat = 1'b0;
    logic          host_mat_wb = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] elem_data;
    logic [2:0]    elem_addr;
    logic          elem_we;
    logic          load_done;
    logic [RW-1:0] res_data = '0;
    logic          res_valid = 1'b0;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          wb_done;
    logic          busy;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    host_responder dut (
        .clk          (clk),
        .rst          (rst),
        .host_req_mat (host_req_mat),
        .host_mat_wb  (host_mat_wb),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .elem_data    (elem_data),
        .elem_addr    (elem_addr),
        .elem_we      (elem_we),
        .load_done    (load_done),
        .res_data     (res_data),
        .res_valid    (res_valid),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .wb_done      (wb_done),
        .busy         (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Monitor: everything the DUT emits, sampled on the falling edge.
    logic [10:0] wr_q[$];
    int          wr_cyc[$];
    logic [7:0]  rx_q[$];
    int          load_done_n = 0, load_done_cyc = 0, wb_done_n = 0, sendv_n = 0;
    logic        prev_stall = 1'b0;
    logic [7:0]  prev_byte = '0;

    always @(negedge clk) begin
        if (elem_we) begin
            wr_q.push_back({elem_addr, elem_data});
            wr_cyc.push_back(cyc);
        end
        if (load_done) begin
            load_done_n++;
            load_done_cyc = cyc;
        end
        if (wb_done) wb_done_n++;
        if (out_valid) sendv_n++;
        if (prev_stall && out_valid) check("out_hold", out_data, prev_byte);
        if (out_valid && out_ready) rx_q.push_back(out_data);
        prev_stall = out_valid && !out_ready;
        prev_byte  = out_data;
    end

    task automatic clear_mon();
        wr_q.delete();
        wr_cyc.delete();
        rx_q.delete();
        load_done_n = 0;
        wb_done_n   = 0;
        sendv_n     = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives a load of up to n_bytes; returns the expected write list (addr = acceptance order).
    task automatic do_load(input int n_bytes, input bit seq, input bit stall, output logic [10:0] exp_w[$]);
        logic [7:0] bytes [8];
        int  k;
        int  budget;
        bit  acc;
        k = 0;
        budget = 0;
        exp_w.delete();
        for (int i = 0; i < 8; i++) bytes[i] = seq ? 8'(i + 1) : 8'($urandom);
        host_req_mat = 1'b1;
        while (k < n_bytes && budget < 200) begin
            in_data  = bytes[k];
            in_valid = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            acc = in_valid && in_ready;
            tick();
            if (acc) begin
                exp_w.push_back({3'(k), bytes[k]});
                k++;
            end
            budget++;
        end
        in_valid     = 1'b0;
        host_req_mat = 1'b0;
        check("load_accepted", k, n_bytes);
        repeat (4) tick();
    endtask

    task automatic cmp_writes(input string tag, input logic [10:0] exp_w[$]);
        check({tag, "_count"}, wr_q.size(), exp_w.size());
        for (int i = 0; i < exp_w.size() && i < wr_q.size(); i++)
            check({tag, "_wr"}, wr_q[i], exp_w[i]);
    endtask

    // Writeback with the given results; rst_after>0 resets once that many bytes were accepted.
    task automatic do_wb(input logic [15:0] res [4], input bit rnd_ready, input int rst_after,
                         output logic [7:0] exp_b[$]);
        int budget;
        exp_b.delete();
        for (int i = 0; i < 4; i++) begin
            exp_b.push_back(res[i][7:0]);
            exp_b.push_back(res[i][15:8]);
        end
        // Junk result in IDLE must be ignored.
        res_valid = 1'b1;
        res_data  = 16'hDEAD;
        tick();
        res_valid   = 1'b0;
        out_ready   = 1'b1;
        host_mat_wb = 1'b1;
        budget = 0;
        do begin
            tick();
            budget++;
        end while (!busy && budget < 20);
        check("wb_enter", busy, 1'b1);
        for (int i = 0; i < 4; i++) begin
            res_valid = 1'b1;
            res_data  = res[i];
            tick();
            host_mat_wb = 1'b0;
            res_valid   = 1'b0;
            repeat ($urandom_range(0, 2)) tick();
        end
        budget = 0;
        while (wb_done_n == 0 && budget < 200) begin
            out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            res_valid = 1'($urandom_range(0, 1));
            res_data  = 16'($urandom);
            tick();
            budget++;
            if (rst_after > 0 && rx_q.size() >= rst_after) begin
                rst = 1'b1;
                #1;
                check("rst_out_valid", out_valid, 1'b0);
                check("rst_busy", busy, 1'b0);
                check("rst_wb_done", wb_done, 1'b0);
                check("rst_out_data", out_data, 8'h00);
                res_valid = 1'b0;
                tick();
                rst = 1'b0;
                tick();
                return;
            end
        end
        res_valid = 1'b0;
        out_ready = 1'b0;
        check("wb_finished", wb_done_n, 1);
        repeat (3) tick();
    endtask

    task automatic cmp_bytes(input string tag, input logic [7:0] exp_b[$]);
        check({tag, "_nbytes"}, rx_q.size(), exp_b.size());
        for (int i = 0; i < exp_b.size() && i < rx_q.size(); i++)
            check({tag, "_byte"}, rx_q[i], exp_b[i]);
    endtask

    initial begin
        logic [10:0] exp_w[$];
        logic [7:0]  exp_b[$];
        logic [15:0] res [4];

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_elem_we", elem_we, 1'b0);
        check("rst_elem_data", elem_data, 8'h00);
        check("rst_elem_addr", elem_addr, 3'd0);
        check("rst_load_done", load_done, 1'b0);
        check("rst_out_valid0", out_valid, 1'b0);
        check("rst_out_data0", out_data, 8'h00);
        check("rst_wb_done0", wb_done, 1'b0);
        check("rst_busy0", busy, 1'b0);
        tick();
        rst = 1'b0;
        tick();

        // Back-to-back load: in_ready low in first LOAD cycle, strobes on consecutive cycles
        clear_mon();
        host_req_mat = 1'b1;
        tick();
        check("load_first_in_ready", in_ready, 1'b0);
        check("load_busy", busy, 1'b1);
        do_load(8, 1'b1, 1'b0, exp_w);
        cmp_writes("b2b", exp_w);
        if (wr_cyc.size() == 8) begin
            check("b2b_consecutive", wr_cyc[7] - wr_cyc[0], 7);
            check("b2b_done_timing", load_done_cyc - wr_cyc[7], 1);
        end
        check("b2b_load_done_n", load_done_n, 1);
        check("b2b_idle", busy, 1'b0);

        // Load with random in_valid stalls
        clear_mon();
        do_load(8, 1'b0, 1'b1, exp_w);
        cmp_writes("stall", exp_w);
        check("stall_load_done_n", load_done_n, 1);

        // Abort after 3 bytes, then a full load restarts at address 0
        clear_mon();
        do_load(3, 1'b0, 1'b0, exp_w);
        cmp_writes("abort", exp_w);
        check("abort_no_done", load_done_n, 0);
        check("abort_idle", busy, 1'b0);
        check("abort_in_ready", in_ready, 1'b0);
        clear_mon();
        do_load(8, 1'b0, 1'b1, exp_w);
        cmp_writes("reload", exp_w);
        check("reload_done_n", load_done_n, 1);

        // Writeback with out_ready held high
        clear_mon();
        res[0] = 16'h1234; res[1] = 16'hABCD; res[2] = 16'h0001; res[3] = 16'hFF00;
        do_wb(res, 1'b0, 0, exp_b);
        cmp_bytes("wb_b2b", exp_b);
        check("wb_b2b_send_cycles", sendv_n, 8);
        check("wb_b2b_idle", busy, 1'b0);

        // Writeback with random backpressure
        clear_mon();
        for (int i = 0; i < 4; i++) res[i] = 16'($urandom);
        do_wb(res, 1'b1, 0, exp_b);
        cmp_bytes("wb_bp", exp_b);

        // Both requests together: LOAD wins (only LOAD raises in_ready)
        clear_mon();
        host_req_mat = 1'b1;
        host_mat_wb  = 1'b1;
        tick();
        tick();
        check("both_in_ready", in_ready, 1'b1);
        host_req_mat = 1'b0;
        host_mat_wb  = 1'b0;
        repeat (3) tick();
        check("both_idle", busy, 1'b0);
        check("both_no_done", load_done_n, 0);
        check("both_no_writes", wr_q.size(), 0);

        // Reset during SEND after 3 bytes, then a fresh writeback
        clear_mon();
        for (int i = 0; i < 4; i++) res[i] = 16'($urandom);
        do_wb(res, 1'b0, 3, exp_b);
        check("midrst_no_done", wb_done_n, 0);
        check("midrst_idle", busy, 1'b0);
        clear_mon();
        for (int i = 0; i < 4; i++) res[i] = 16'($urandom);
        do_wb(res, 1'b1, 0, exp_b);
        cmp_bytes("post_rst", exp_b);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
